// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the PLL lock controller: state encoding,
// retry counter width and the sizing function for the shared cycle counter.
package pll_ctrl_pkg;

  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_RECOVER   = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  // Width needed to hold the largest of the four cycle-count parameters.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer for the asynchronous PLL lock indication.
// Latency: 2 cycles; no flow control.
module pll_lock_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/pll_lock_controller.sv
// Sequences one PLL: enable, lock qualification, clock gating, downstream reset
// release, retry on timeout/lock loss and a sticky fault. Outputs are registered.
module pll_lock_controller
  import pll_ctrl_pkg::*;
#(
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int STABLE_CYCLES = 64,
  parameter int RESET_DELAY   = 16,
  parameter int OFF_CYCLES    = 8,
  parameter int MAX_RETRIES   = 3
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_lock,
  output logic               o_pll_en,
  output logic               o_clk_en,
  output logic               o_reset_out,
  output logic               o_ready,
  output logic               o_fault,
  output logic               o_lock_lost,
  output logic [RETRY_W-1:0] o_retry_cnt,
  output logic [2:0]         o_state
);

  localparam int CNT_W = cnt_width(LOCK_TIMEOUT, STABLE_CYCLES, RESET_DELAY, OFF_CYCLES);
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_STABLE  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_RSTDLY  = CNT_W'(RESET_DELAY - 1);
  localparam logic [CNT_W-1:0] C_OFF     = CNT_W'(OFF_CYCLES - 1);
  localparam logic [RETRY_W-1:0] C_MAX_RETRY = RETRY_W'(MAX_RETRIES);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [RETRY_W-1:0] r_retry;
  logic               r_pll_en;
  logic               r_clk_en;
  logic               r_reset_out;
  logic               r_ready;
  logic               r_fault;
  logic               r_lock_lost;

  state_t w_next;
  state_t w_fail_state;
  logic   w_lock_s;
  logic   w_lock_drop;
  logic   w_counting;

  pll_lock_sync u_lock_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_lock),
    .o_sync  (w_lock_s)
  );

  assign w_fail_state = (r_retry == C_MAX_RETRY) ? ST_FAULT : ST_RECOVER;
  assign w_lock_drop  = (r_state == ST_RUN) && i_start && !w_lock_s;
  assign w_counting   = (r_state inside {ST_WAIT_LOCK, ST_STABILIZE, ST_RELEASE, ST_RECOVER});

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:      if (i_start) w_next = ST_WAIT_LOCK;
      // Lock seen on the timeout cycle still counts as success.
      ST_WAIT_LOCK: begin
        if (w_lock_s)                w_next = ST_STABILIZE;
        else if (r_cnt == C_TIMEOUT) w_next = w_fail_state;
      end
      ST_STABILIZE: begin
        if (!w_lock_s)              w_next = w_fail_state;
        else if (r_cnt == C_STABLE) w_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!w_lock_s)              w_next = w_fail_state;
        else if (r_cnt == C_RSTDLY) w_next = ST_RUN;
      end
      ST_RUN:       if (!w_lock_s) w_next = ST_RECOVER;
      ST_RECOVER:   if (r_cnt == C_OFF) w_next = ST_WAIT_LOCK;
      ST_FAULT:     w_next = ST_FAULT;
      default:      w_next = ST_IDLE;
    endcase
    if (!i_start && r_state != ST_IDLE) w_next = ST_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_pll_en    <= 1'b0;
      r_clk_en    <= 1'b0;
      r_reset_out <= 1'b1;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state || !w_counting) r_cnt <= '0;
      else                                  r_cnt <= r_cnt + CNT_W'(1);

      if (r_state == ST_IDLE && w_next == ST_WAIT_LOCK)
        r_retry <= '0;
      else if (r_state != ST_RUN && w_next == ST_RUN)
        r_retry <= '0;
      else if (r_state == ST_RECOVER && w_next == ST_WAIT_LOCK && r_retry != '1)
        r_retry <= r_retry + RETRY_W'(1);

      // Outputs decode the next state so they move on the same edge as r_state.
      r_pll_en    <= (w_next inside {ST_WAIT_LOCK, ST_STABILIZE, ST_RELEASE, ST_RUN});
      r_clk_en    <= (w_next inside {ST_RELEASE, ST_RUN});
      r_reset_out <= (w_next != ST_RUN);
      r_ready     <= (w_next == ST_RUN);
      r_fault     <= (w_next == ST_FAULT);
      r_lock_lost <= w_lock_drop;
    end
  end

  assign o_pll_en    = r_pll_en;
  assign o_clk_en    = r_clk_en;
  assign o_reset_out = r_reset_out;
  assign o_ready     = r_ready;
  assign o_fault     = r_fault;
  assign o_lock_lost = r_lock_lost;
  assign o_retry_cnt = r_retry;
  assign o_state     = r_state;

endmodule

// File: tb/tb_pll_lock_controller.sv
// Directed bench for pll_lock_controller: table of {inputs, cycles, expected}
// rows plus hand sequences for the timeout boundary and the fault pulse count.
module tb_pll_lock_controller;

  logic       clk;
  logic       rst;
  logic       start;
  logic       lock;
  logic       pll_en;
  logic       clk_en;
  logic       reset_out;
  logic       ready;
  logic       fault;
  logic       lock_lost;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic       start;
    logic       lock;
    int         cyc;
    logic [2:0] exp_state;
    logic [3:0] exp_retry;
    logic       exp_lost;
  } vec_t;

  vec_t tbl[$];

  pll_lock_controller #(
    .LOCK_TIMEOUT  (64),
    .STABLE_CYCLES (16),
    .RESET_DELAY   (8),
    .OFF_CYCLES    (4),
    .MAX_RETRIES   (2)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_lock      (lock),
    .o_pll_en    (pll_en),
    .o_clk_en    (clk_en),
    .o_reset_out (reset_out),
    .o_ready     (ready),
    .o_fault     (fault),
    .o_lock_lost (lock_lost),
    .o_retry_cnt (retry_cnt),
    .o_state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int row, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s row=%0d got=%0d want=%0d", name, row, got, want);
    end
  endtask

  // Expected Moore outputs follow from the expected state encoding.
  task automatic check_all(input int row, input logic [2:0] st, input logic [3:0] rc, input logic lost);
    logic e_pll, e_clk, e_rst, e_rdy, e_flt;
    e_pll = (st == 3'd1) || (st == 3'd2) || (st == 3'd3) || (st == 3'd4);
    e_clk = (st == 3'd3) || (st == 3'd4);
    e_rst = (st != 3'd4);
    e_rdy = (st == 3'd4);
    e_flt = (st == 3'd6);
    chk("state",     row, {5'b0, state},     {5'b0, st});
    chk("pll_en",    row, {7'b0, pll_en},    {7'b0, e_pll});
    chk("clk_en",    row, {7'b0, clk_en},    {7'b0, e_clk});
    chk("reset_out", row, {7'b0, reset_out}, {7'b0, e_rst});
    chk("ready",     row, {7'b0, ready},     {7'b0, e_rdy});
    chk("fault",     row, {7'b0, fault},     {7'b0, e_flt});
    chk("lock_lost", row, {7'b0, lock_lost}, {7'b0, lost});
    chk("retry_cnt", row, {4'b0, retry_cnt}, {4'b0, rc});
  endtask

  task automatic add(input logic r, input logic s, input logic l, input int c,
                     input logic [2:0] st, input logic [3:0] rc, input logic lost);
    vec_t v;
    v.rst = r; v.start = s; v.lock = l; v.cyc = c;
    v.exp_state = st; v.exp_retry = rc; v.exp_lost = lost;
    tbl.push_back(v);
  endtask

  initial begin
    int pulses;
    logic prev_en;

    rst = 1'b1;
    start = 1'b0;
    lock = 1'b0;

    // Normal start-up, LOCK rises at cycle 20 (comments give the cycle after the row).
    add(1, 0, 0,  2, 3'd0, 0, 0); // 0  reset values
    add(0, 1, 0,  1, 3'd1, 0, 0); // 1
    add(0, 1, 0, 19, 3'd1, 0, 0); // 20
    add(0, 1, 1,  2, 3'd1, 0, 0); // 22 lock_s just high
    add(0, 1, 1,  1, 3'd2, 0, 0); // 23
    add(0, 1, 1, 15, 3'd2, 0, 0); // 38
    add(0, 1, 1,  1, 3'd3, 0, 0); // 39
    add(0, 1, 1,  7, 3'd3, 0, 0); // 46
    add(0, 1, 1,  1, 3'd4, 0, 0); // 47
    add(0, 1, 1,  3, 3'd4, 0, 0); // 50
    // Lock loss in RUN at t=50.
    add(0, 1, 0,  2, 3'd4, 0, 0); // 52
    add(0, 1, 0,  1, 3'd5, 0, 1); // 53 LOCK_LOST pulse
    add(0, 1, 0,  1, 3'd5, 0, 0); // 54
    add(0, 1, 0,  3, 3'd1, 1, 0); // 57
    // Glitch during STABILIZE (LOCK low cycles 13..15).
    add(1, 0, 0,  2, 3'd0, 0, 0); // 0
    add(0, 1, 1,  2, 3'd1, 0, 0); // 2
    add(0, 1, 1,  1, 3'd2, 0, 0); // 3
    add(0, 1, 1, 10, 3'd2, 0, 0); // 13
    add(0, 1, 0,  2, 3'd2, 0, 0); // 15
    add(0, 1, 0,  1, 3'd5, 0, 0); // 16
    add(0, 1, 1,  3, 3'd5, 0, 0); // 19
    add(0, 1, 1,  1, 3'd1, 1, 0); // 20
    add(0, 1, 1,  1, 3'd2, 1, 0); // 21
    add(0, 1, 1, 16, 3'd3, 1, 0); // 37
    add(0, 1, 1,  8, 3'd4, 0, 0); // 45
    // START drop mid-RELEASE, then reset mid-RUN.
    add(1, 0, 1,  2, 3'd0, 0, 0); // 0
    add(0, 1, 1, 20, 3'd3, 0, 0); // 20
    add(0, 0, 1,  1, 3'd0, 0, 0); // 21
    add(0, 1, 1, 26, 3'd4, 0, 0); // 47
    add(1, 1, 1,  1, 3'd0, 0, 0); // reset values
    // Timeout with LOCK stuck low.
    add(1, 0, 0,  2, 3'd0, 0, 0); // 0
    add(0, 1, 0, 64, 3'd1, 0, 0); // 64
    add(0, 1, 0,  1, 3'd5, 0, 0); // 65
    add(0, 1, 0,  3, 3'd5, 0, 0); // 68
    add(0, 1, 0,  1, 3'd1, 1, 0); // 69
    add(0, 1, 0, 63, 3'd1, 1, 0); // 132
    add(0, 1, 0,  1, 3'd5, 1, 0); // 133
    add(0, 1, 0,  4, 3'd1, 2, 0); // 137
    add(0, 1, 0, 63, 3'd1, 2, 0); // 200
    add(0, 1, 0,  1, 3'd6, 2, 0); // 201
    add(0, 1, 1, 40, 3'd6, 2, 0); // LOCK ignored in FAULT
    add(0, 0, 1,  1, 3'd0, 2, 0); // IDLE, fault cleared

    foreach (tbl[i]) begin
      rst   = tbl[i].rst;
      start = tbl[i].start;
      lock  = tbl[i].lock;
      repeat (tbl[i].cyc) step();
      check_all(i, tbl[i].exp_state, tbl[i].exp_retry, tbl[i].exp_lost);
    end

    // lock_s rises exactly when cnt==63 in WAIT_LOCK: lock must win.
    rst = 1'b1; start = 1'b0; lock = 1'b0;
    repeat (2) step();
    rst = 1'b0; start = 1'b1;
    repeat (62) step();
    lock = 1'b1;
    repeat (2) step();
    check_all(100, 3'd1, 0, 0);
    step();
    check_all(101, 3'd2, 0, 0);

    // Timeout run: exactly three PLL_EN pulses, none after FAULT.
    rst = 1'b1; start = 1'b0; lock = 1'b0;
    repeat (2) step();
    rst = 1'b0; start = 1'b1;
    pulses = 0;
    prev_en = pll_en;
    for (int c = 0; c < 280; c++) begin
      step();
      if (pll_en && !prev_en) pulses++;
      prev_en = pll_en;
    end
    chk("pll_en_pulses", 200, 8'(pulses), 8'd3);
    check_all(201, 3'd6, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
